// File: rtl/sprite_row_fetcher_pkg.sv
// Shared types for the tank sprite row fetcher: frame select encoding, default geometry, FSM states.
// No logic here; latency/backpressure are properties of the modules that import it.
package sprite_row_fetcher_pkg;

    localparam int SPR_DIM_DEF = 32;
    localparam int PIX_W_DEF   = 4;

    typedef enum logic [2:0] {
        UP1    = 3'd0,
        UP2    = 3'd1,
        DOWN1  = 3'd2,
        DOWN2  = 3'd3,
        LEFT1  = 3'd4,
        LEFT2  = 3'd5,
        RIGHT1 = 3'd6,
        RIGHT2 = 3'd7
    } tank_dir_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sprite_row_fetcher_rr_arbiter.sv
// Combinational requester pick, zero latency, no backpressure; round-robin after last_winner,
// or lowest index first when SPRITE_ROW_FETCHER_FIXED_PRIO_EN is defined (last_winner port removed).
module rr_arbiter
    import sprite_row_fetcher_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifndef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
    input  logic [IW-1:0]    last_winner,
`endif
    output logic [N_REQ-1:0] winner_oh,
    output logic [IW-1:0]    winner_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = '0;
`ifdef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'(i);
`else
        // Search starts one past the previous winner and wraps.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(last_winner) + i) % N_REQ);
`endif
            if (!found && req[idx]) begin
                found          = 1'b1;
                winner_oh[idx] = 1'b1;
                winner_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/sprite_row_fetcher.sv
// Grants the shared sprite ROM to one requester and streams its 32-pixel row; rd_* lag rom_* by 1 cycle.
// No output backpressure; requests wait in IDLE. SPRITE_ROW_FETCHER_FIXED_PRIO_EN selects fixed priority.
module sprite_row_fetcher
    import sprite_row_fetcher_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int SPR_DIM = SPR_DIM_DEF,
    parameter  int PIX_W   = PIX_W_DEF,
    localparam int IW      = $clog2(N_REQ),
    localparam int CW      = $clog2(SPR_DIM)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] req_row,
    input  logic [N_REQ*3-1:0]  req_dir,
    output logic [N_REQ-1:0]    grant,
    output logic                busy,
    output logic [CW-1:0]       rom_row,
    output logic [CW-1:0]       rom_col,
    output logic [2:0]          rom_dir,
    input  logic [PIX_W-1:0]    rom_data,
    output logic                rd_valid,
    output logic [IW-1:0]       rd_id,
    output logic [CW-1:0]       rd_col,
    output logic [PIX_W-1:0]    rd_data,
    output logic                rd_last
);

    localparam logic [CW-1:0] COL_LAST = CW'(SPR_DIM - 1);

    fetch_state_e     state, state_next;
    logic [N_REQ-1:0] grant_next;
    logic [IW-1:0]    owner, owner_next;
    logic [CW-1:0]    row_next, col_next;
    tank_dir_e        dir_q, dir_next;
    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic [CW-1:0]    row_arr [N_REQ];
    logic [2:0]       dir_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign row_arr[i] = req_row[i*CW +: CW];
        assign dir_arr[i] = req_dir[i*3 +: 3];
    end

`ifdef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req),
        .winner_oh  (win_oh),
        .winner_idx (win_idx)
    );
`else
    logic [IW-1:0] last_winner, last_winner_next;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req         (req),
        .last_winner (last_winner),
        .winner_oh   (win_oh),
        .winner_idx  (win_idx)
    );
`endif

    always_comb begin
        state_next = state;
        grant_next = '0;
        owner_next = owner;
        row_next   = rom_row;
        col_next   = rom_col;
        dir_next   = dir_q;
`ifndef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
        last_winner_next = last_winner;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = BURST;
                    grant_next = win_oh;
                    owner_next = win_idx;
                    row_next   = row_arr[win_idx];
                    dir_next   = tank_dir_e'(dir_arr[win_idx]);
                    col_next   = '0;
`ifndef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
                    last_winner_next = win_idx;
`endif
                end
            end
            BURST: begin
                // Column parks on the last value so the ROM address holds through IDLE.
                if (rom_col == COL_LAST) begin
                    state_next = IDLE;
                end else begin
                    col_next = rom_col + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rom_row  <= '0;
            rom_col  <= '0;
            dir_q    <= UP1;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_col   <= '0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
`ifndef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
            last_winner <= IW'(N_REQ - 1);
`endif
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            owner    <= owner_next;
            rom_row  <= row_next;
            rom_col  <= col_next;
            dir_q    <= dir_next;
            rd_valid <= (state == BURST);
            rd_last  <= (state == BURST) && (rom_col == COL_LAST);
            if (state == BURST) begin
                rd_id   <= owner;
                rd_col  <= rom_col;
                rd_data <= rom_data;
            end
`ifndef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
            last_winner <= last_winner_next;
`endif
        end
    end

    assign busy    = (state == BURST);
    assign rom_dir = dir_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Bench for sprite_row_fetcher: vector table of request patterns, pixel scoreboard, hand-timed corner sequences.
module tb_sprite_row_fetcher;
    import sprite_row_fetcher_pkg::*;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int PW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [N-1:0]  req;
    logic [N*CW-1:0] req_row;
    logic [N*3-1:0]  req_dir;
    logic [N-1:0]  grant;
    logic          busy;
    logic [CW-1:0] rom_row, rom_col;
    logic [2:0]    rom_dir;
    logic [PW-1:0] rom_data;
    logic          rd_valid;
    logic [1:0]    rd_id;
    logic [CW-1:0] rd_col;
    logic [PW-1:0] rd_data;
    logic          rd_last;

    always #5 Clk = ~Clk;

    // ROM model: pixel = row ^ col, truncated to the palette width.
    assign rom_data = PW'(rom_row ^ rom_col);

    sprite_row_fetcher #(.N_REQ(N), .SPR_DIM(32), .PIX_W(PW)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_row(req_row), .req_dir(req_dir),
        .grant(grant), .busy(busy), .rom_row(rom_row), .rom_col(rom_col), .rom_dir(rom_dir),
        .rom_data(rom_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_col(rd_col),
        .rd_data(rd_data), .rd_last(rd_last)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic [4:0]    col;
        logic [3:0]    data;
        logic          last;
    } pix_t;

    typedef struct packed {
        logic [3:0]       mask;
        logic [3:0][4:0]  rows;
        logic [3:0][2:0]  dirs;
        logic [2:0]       n;
        logic [3:0][1:0]  order;
    } vec_t;

    pix_t sb[$];
    pix_t exp_pix;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_g = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pixel monitor: every rd_valid beat must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got id %0d col %0d, expected no output", rd_id, rd_col);
                end else begin
                    exp_pix = sb.pop_front();
                    check("pixel", {rd_id, rd_col, rd_data, rd_last}, exp_pix);
                end
            end
            if (|grant) check("grant_pulse", prev_g, 1'b0);
        end
        prev_g = |grant;
    end

    task automatic push_burst(input int id, input logic [4:0] row);
        pix_t p;
        for (int c = 0; c < 32; c++) begin
            p.id   = 2'(id);
            p.col  = 5'(c);
            p.data = PW'(row ^ 5'(c));
            p.last = (c == 31);
            sb.push_back(p);
        end
    endtask

    task automatic wait_grant(output logic [3:0] g, output int waited);
        g = '0;
        waited = 0;
        while (g == 0 && waited < 200) begin
            @(posedge Clk); #1;
            waited++;
            g = grant;
        end
        if (g == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant after %0d cycles, expected one", waited);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while ((busy || sb.size() != 0) && n < 500);
        if (busy || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %0b pending %0d, expected idle and drained", busy, sb.size());
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] g, eg;
        int w, prev, id;
        wait_idle();
        for (int i = 0; i < N; i++) begin
            req_row[i*CW +: CW] = v.rows[i];
            req_dir[i*3 +: 3]   = v.dirs[i];
        end
        for (int k = 0; k < int'(v.n); k++) push_burst(int'(v.order[k]), v.rows[v.order[k]]);
        req = v.mask;
        prev = 0;
        for (int k = 0; k < int'(v.n); k++) begin
            wait_grant(g, w);
            id = int'(v.order[k]);
            eg = 4'(1 << id);
            check("grant_order", g, eg);
            if (k == 0) check("grant_latency", w, 1);
            else        check("grant_spacing", cyc - prev, 33);
            prev = cyc;
            check("rom_addr", {rom_row, rom_col, rom_dir}, {v.rows[id], 5'd0, v.dirs[id]});
            req = req & ~g;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        int w, n;

        vecs[0] = '{mask:4'b1111, rows:{5'd8, 5'd30, 5'd17, 5'd3}, dirs:{LEFT2, RIGHT1, DOWN2, UP1},
                    n:3'd4, order:{2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{mask:4'b1010, rows:{5'd14, 5'd0, 5'd21, 5'd0}, dirs:{RIGHT2, UP1, LEFT1, UP1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[2] = '{mask:4'b0101, rows:{5'd0, 5'd1, 5'd0, 5'd31}, dirs:{UP1, UP2, UP1, DOWN1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd2, 2'd0}};
`ifdef SPRITE_ROW_FETCHER_FIXED_PRIO_EN
        vecs[3] = '{mask:4'b1001, rows:{5'd25, 5'd0, 5'd0, 5'd6}, dirs:{UP1, UP1, UP1, RIGHT1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd3, 2'd0}};
`else
        vecs[3] = '{mask:4'b1001, rows:{5'd25, 5'd0, 5'd0, 5'd6}, dirs:{UP1, UP1, UP1, RIGHT1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd0, 2'd3}};
`endif
        vecs[4] = '{mask:4'b0110, rows:{5'd0, 5'd19, 5'd11, 5'd0}, dirs:{UP1, DOWN1, LEFT2, UP1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[5] = '{mask:4'b1010, rows:{5'd27, 5'd0, 5'd2, 5'd0}, dirs:{LEFT1, UP1, UP2, UP1},
                    n:3'd2, order:{2'd0, 2'd0, 2'd3, 2'd1}};

        Reset = 1'b1;
        req = '0;
        req_row = '0;
        req_dir = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_state", {grant, busy, rd_valid, rd_last, rd_id, rd_col, rd_data, rom_row, rom_col, rom_dir}, 32'd0);

        // Fairness, wrap-around and arbitration-policy vectors.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Single burst with exact cycle positions.
        wait_idle();
        req_row[2*CW +: CW] = 5'd5;
        req_dir[2*3 +: 3]   = LEFT1;
        push_burst(2, 5'd5);
        req = 4'b0100;
        @(posedge Clk); #1;
        check("single_t1", {grant, busy, rom_row, rom_col, rom_dir}, {4'b0100, 1'b1, 5'd5, 5'd0, 3'd4});
        req = '0;
        @(posedge Clk); #1;
        check("single_t2", {grant, rd_valid, rd_col, rom_col}, {4'b0000, 1'b1, 5'd0, 5'd1});
        repeat (30) @(posedge Clk);
        #1 check("single_t32", {busy, rom_col, rd_last}, {1'b1, 5'd31, 1'b0});
        @(posedge Clk); #1;
        check("single_t33", {busy, rd_valid, rd_last, rd_col, rom_col}, {1'b0, 1'b1, 1'b1, 5'd31, 5'd31});
        @(posedge Clk); #1;
        check("single_t34", {rd_valid, rd_last}, 2'b00);

        // Request held through a burst yields a second burst after one idle cycle.
        wait_idle();
        req_row[0 +: CW] = 5'd9;
        req_dir[0 +: 3]  = RIGHT2;
        push_burst(0, 5'd9);
        push_burst(0, 5'd9);
        req = 4'b0001;
        wait_grant(g, w);
        check("held_grant1", g, 4'b0001);
        repeat (32) @(posedge Clk);
        #1 check("held_gap", {busy, rom_col}, {1'b0, 5'd31});
        wait_grant(g, w);
        check("held_grant2", {g, 8'(w), rom_col}, {4'b0001, 8'd1, 5'd0});
        req = '0;

        // Idle quiet: nothing moves and the ROM address holds.
        wait_idle();
        repeat (100) begin
            @(posedge Clk); #1;
            check("idle_quiet", {busy, grant, rd_valid, rom_row, rom_col, rom_dir},
                  {1'b0, 4'b0000, 1'b0, 5'd9, 5'd31, 3'd7});
        end

        // Reset in the middle of a burst.
        req_row[2*CW +: CW] = 5'd12;
        req_dir[2*3 +: 3]   = UP2;
        push_burst(2, 5'd12);
        req = 4'b0100;
        wait_grant(g, w);
        check("rst_burst_grant", g, 4'b0100);
        req = '0;
        n = 0;
        while (!(rd_valid && rd_col == 5'd10) && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        check("rst_reach_col10", {rd_valid, rd_col}, {1'b1, 5'd10});
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        sb.delete();
        check("rst_outputs", {grant, busy, rd_valid, rd_last, rd_id, rd_col, rd_data, rom_row, rom_col, rom_dir}, 32'd0);
        @(posedge Clk); #1;
        check("rst_quiet", {busy, rd_valid, grant}, 6'd0);
        run_vec(vecs[5]);

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
